// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryption core: one inverse round per clock, round keys expanded
// in-core into an 11-entry register file and consumed from rk[10] down to rk[0].
module aes_decrypt_iter #(
   parameter bit KEY_CACHE = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] ciphertext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] plaintext,
   output logic         key_hit
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_KEYEXP = 2'd1;
   localparam logic [1:0] ST_ROUND  = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   // Byte x of a table sits at bits [2047-8x -: 8]; ~x gives 255-x for the offset.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return INV_SBOX[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] k);
      case (k)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = 128'h0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = 128'h0;
      for (int i = 0; i < 16; i++) begin
         o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
      end
      return o;
   endfunction

   // Row i of the inverse matrix is [0e 0b 0d 09] rotated right by i.
   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      logic [31:0] o;
      o = 32'h0;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31 - 8 * i -: 8];
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      for (int i = 0; i < 4; i++) begin
         o[31 - 8 * i -: 8] = me[i] ^ mb[(i + 1) % 4] ^ md[(i + 2) % 4] ^ m9[(i + 3) % 4];
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
              inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
   endfunction

   function automatic logic [127:0] key_step(input logic [127:0] p, input logic [7:0] rc);
      logic [31:0] t, w0, w1, w2, w3;
      t  = {sbox(p[23:16]), sbox(p[15:8]), sbox(p[7:0]), sbox(p[31:24])} ^ {rc, 24'h000000};
      w0 = p[127:96] ^ t;
      w1 = p[95:64] ^ w0;
      w2 = p[63:32] ^ w1;
      w3 = p[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   logic [1:0]   fsm_r;
   logic [3:0]   k_r;
   logic [3:0]   r_r;
   logic [127:0] state_r;
   logic [127:0] ct_r;
   logic [127:0] key_cache_r;
   logic         cache_valid_r;
   logic         in_ready_r;
   logic         out_valid_r;
   logic [127:0] plaintext_r;
   logic         key_hit_r;
   logic [127:0] rk_r [0:10];

   logic         accept_s;
   logic         hit_s;
   logic [127:0] rk_next_s;
   logic [127:0] t_s;
   logic [127:0] imc_s;

   // Handshake decode and the shared key-step / inverse-round datapaths.
   always_comb begin
      accept_s  = (fsm_r == ST_IDLE) && in_valid && in_ready_r;
      hit_s     = KEY_CACHE && cache_valid_r && (key == key_cache_r);
      rk_next_s = key_step(rk_r[k_r - 4'd1], rcon(k_r));
      t_s       = inv_sub_bytes(inv_shift_rows(state_r)) ^ rk_r[r_r];
      imc_s     = inv_mix_columns(t_s);
   end

   // Round-key file: rk[0] loaded on a miss accept, rk[1..10] filled during KEYEXP.
   always_ff @(posedge clk) begin
      if (accept_s && !hit_s) begin
         rk_r[0] <= key;
      end else if (fsm_r == ST_KEYEXP) begin
         rk_r[k_r] <= rk_next_s;
      end
   end

   // Control FSM, state register and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_r         <= ST_IDLE;
         k_r           <= 4'd0;
         r_r           <= 4'd0;
         state_r       <= 128'h0;
         ct_r          <= 128'h0;
         key_cache_r   <= 128'h0;
         cache_valid_r <= 1'b0;
         in_ready_r    <= 1'b1;
         out_valid_r   <= 1'b0;
         plaintext_r   <= 128'h0;
         key_hit_r     <= 1'b0;
      end else begin
         key_hit_r <= 1'b0;
         case (fsm_r)
            ST_IDLE: begin
               if (accept_s) begin
                  in_ready_r <= 1'b0;
                  ct_r       <= ciphertext;
                  if (hit_s) begin
                     state_r   <= ciphertext ^ rk_r[10];
                     r_r       <= 4'd9;
                     key_hit_r <= 1'b1;
                     fsm_r     <= ST_ROUND;
                  end else begin
                     // Cache stays invalid until the new schedule is complete.
                     key_cache_r   <= key;
                     cache_valid_r <= 1'b0;
                     k_r           <= 4'd1;
                     fsm_r         <= ST_KEYEXP;
                  end
               end
            end
            ST_KEYEXP: begin
               k_r <= k_r + 4'd1;
               if (k_r == 4'd10) begin
                  state_r       <= ct_r ^ rk_next_s;
                  cache_valid_r <= 1'b1;
                  r_r           <= 4'd9;
                  fsm_r         <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               r_r <= r_r - 4'd1;
               if (r_r == 4'd0) begin
                  plaintext_r <= t_s;
                  out_valid_r <= 1'b1;
                  fsm_r       <= ST_DONE;
               end else begin
                  state_r <= imc_s;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  fsm_r       <= ST_IDLE;
               end
            end
            default: begin
               fsm_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign plaintext = plaintext_r;
   assign key_hit   = key_hit_r;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed FIPS-197 vectors against a caching and a non-caching build of aes_decrypt_iter.
module tb_aes_decrypt_iter;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         out_ready;
   logic         sel;
   logic [127:0] ct;
   logic [127:0] key;

   logic         in_valid_a, out_ready_a, in_ready_a, out_valid_a, key_hit_a;
   logic         in_valid_b, out_ready_b, in_ready_b, out_valid_b, key_hit_b;
   logic [127:0] plaintext_a, plaintext_b;
   logic         cur_in_ready, cur_out_valid, cur_key_hit;
   logic [127:0] cur_plaintext;

   int checks;
   int errors;

   assign in_valid_a    = in_valid & ~sel;
   assign in_valid_b    = in_valid & sel;
   assign out_ready_a   = out_ready & ~sel;
   assign out_ready_b   = out_ready & sel;
   assign cur_in_ready  = sel ? in_ready_b : in_ready_a;
   assign cur_out_valid = sel ? out_valid_b : out_valid_a;
   assign cur_key_hit   = sel ? key_hit_b : key_hit_a;
   assign cur_plaintext = sel ? plaintext_b : plaintext_a;

   aes_decrypt_iter #(.KEY_CACHE(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .ciphertext(ct), .key(key), .out_valid(out_valid_a), .out_ready(out_ready_a),
      .plaintext(plaintext_a), .key_hit(key_hit_a)
   );

   aes_decrypt_iter #(.KEY_CACHE(1'b0)) dut_nc (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .ciphertext(ct), .key(key), .out_valid(out_valid_b), .out_ready(out_ready_b),
      .plaintext(plaintext_b), .key_hit(key_hit_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic do_req(input logic [127:0] c, input logic [127:0] k, input logic [127:0] p,
                         input int lat, input logic hit, input int hold, input string tag);
      int n;
      logic seen;
      @(negedge clk);
      in_valid = 1'b1;
      ct       = c;
      key      = k;
      check_val({tag, "_rdy_before"}, {127'h0, cur_in_ready}, 128'h1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      ct       = ~c;
      key      = ~k;
      check_val({tag, "_key_hit"}, {127'h0, cur_key_hit}, {127'h0, hit});
      check_val({tag, "_rdy_busy"}, {127'h0, cur_in_ready}, 128'h0);
      n    = 0;
      seen = 1'b0;
      while (!cur_out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (cur_key_hit) seen = 1'b1;
      end
      check_val({tag, "_latency"}, 128'(n), 128'(lat));
      check_val({tag, "_hit_late"}, {127'h0, seen}, 128'h0);
      check_val({tag, "_plaintext"}, cur_plaintext, p);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check_val({tag, "_bp_valid"}, {127'h0, cur_out_valid}, 128'h1);
         check_val({tag, "_bp_pt"}, cur_plaintext, p);
         check_val({tag, "_bp_rdy"}, {127'h0, cur_in_ready}, 128'h0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_val({tag, "_valid_drop"}, {127'h0, cur_out_valid}, 128'h0);
      check_val({tag, "_rdy_back"}, {127'h0, cur_in_ready}, 128'h1);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sel       = 1'b0;
      ct        = 128'h0;
      key       = 128'h0;
      #12;
      check_val("rst_in_ready", {127'h0, in_ready_a}, 128'h1);
      check_val("rst_out_valid", {127'h0, out_valid_a}, 128'h0);
      check_val("rst_plaintext", plaintext_a, 128'h0);
      check_val("rst_key_hit", {127'h0, key_hit_a}, 128'h0);
      @(negedge clk);
      rst = 1'b0;

      do_req(C1_CT, C1_KEY, C1_PT, 20, 1'b0, 0, "c1_miss");
      do_req(C1_CT, C1_KEY, C1_PT, 10, 1'b1, 0, "c1_hit");
      do_req(B_CT, B_KEY, B_PT, 20, 1'b0, 0, "appb_miss");
      do_req(C1_CT, C1_KEY, C1_PT, 20, 1'b0, 7, "c1_bp");

      // Cached-key request interrupted by reset in the middle of its rounds.
      @(negedge clk);
      in_valid = 1'b1;
      ct       = C1_CT;
      key      = C1_KEY;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_val("midrst_in_ready", {127'h0, in_ready_a}, 128'h1);
      check_val("midrst_out_valid", {127'h0, out_valid_a}, 128'h0);
      check_val("midrst_plaintext", plaintext_a, 128'h0);
      check_val("midrst_key_hit", {127'h0, key_hit_a}, 128'h0);
      repeat (2) @(posedge clk);
      #1;
      check_val("midrst_hold_valid", {127'h0, out_valid_a}, 128'h0);
      @(negedge clk);
      rst = 1'b0;
      do_req(C1_CT, C1_KEY, C1_PT, 20, 1'b0, 0, "c1_after_rst");

      sel = 1'b1;
      do_req(C1_CT, C1_KEY, C1_PT, 20, 1'b0, 0, "nc_first");
      do_req(C1_CT, C1_KEY, C1_PT, 20, 1'b0, 0, "nc_second");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
